// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone IO arbiter.
package wb_arb_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CTI_W = 3;
    localparam int unsigned BTE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic             we;
        logic             cyc;
        logic             stb;
        logic [CTI_W-1:0] cti;
        logic [BTE_W-1:0] bte;
    } wb_req_t;

    typedef struct packed {
        logic [DAT_W-1:0] dat;
        logic             ack;
        logic             err;
        logic             rty;
    } wb_rsp_t;

endpackage

// File: rtl/wb_tmo_cnt.sv
// Per-transfer watchdog: counts consecutive unterminated strobe cycles and flags expiry.
module wb_tmo_cnt #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire_c = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count;

            assign expire_c = en && !clr && (count == LAST);

            // Saturates at LAST; the arbiter leaves BUSY on expiry so it never wraps.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clr) begin
                    count <= '0;
                end else if (en && (count != LAST)) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/wb_io_arbiter.sv
// Round-robin two-master Wishbone arbiter onto the wb_io port, grant held per cyc,
// with a watchdog that aborts unterminated accesses.
module wb_io_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic [31:0] wb_m0_adr_i,
    input  logic [31:0] wb_m0_dat_i,
    input  logic [3:0]  wb_m0_sel_i,
    input  logic        wb_m0_we_i,
    input  logic        wb_m0_cyc_i,
    input  logic        wb_m0_stb_i,
    input  logic [2:0]  wb_m0_cti_i,
    input  logic [1:0]  wb_m0_bte_i,
    output logic [31:0] wb_m0_dat_o,
    output logic        wb_m0_ack_o,
    output logic        wb_m0_err_o,
    output logic        wb_m0_rty_o,

    input  logic [31:0] wb_m1_adr_i,
    input  logic [31:0] wb_m1_dat_i,
    input  logic [3:0]  wb_m1_sel_i,
    input  logic        wb_m1_we_i,
    input  logic        wb_m1_cyc_i,
    input  logic        wb_m1_stb_i,
    input  logic [2:0]  wb_m1_cti_i,
    input  logic [1:0]  wb_m1_bte_i,
    output logic [31:0] wb_m1_dat_o,
    output logic        wb_m1_ack_o,
    output logic        wb_m1_err_o,
    output logic        wb_m1_rty_o,

    output logic [31:0] wb_io_adr_o,
    output logic [31:0] wb_io_dat_o,
    output logic [3:0]  wb_io_sel_o,
    output logic        wb_io_we_o,
    output logic        wb_io_cyc_o,
    output logic        wb_io_stb_o,
    output logic [2:0]  wb_io_cti_o,
    output logic [1:0]  wb_io_bte_o,
    input  logic [31:0] wb_io_dat_i,
    input  logic        wb_io_ack_i,
    input  logic        wb_io_err_i,
    input  logic        wb_io_rty_i,

    output logic        tmo_o,
    output logic [31:0] tmo_adr_o,
    output logic        tmo_mst_o
);

    arb_state_e state;
    logic       owner;
    logic       last;

    wb_req_t req_m0, req_m1, req_own, req_io;
    wb_rsp_t rsp_own;
    logic    term, cnt_en, cnt_clr, expire_c;

    assign req_m0 = '{adr: wb_m0_adr_i, dat: wb_m0_dat_i, sel: wb_m0_sel_i, we: wb_m0_we_i,
                      cyc: wb_m0_cyc_i, stb: wb_m0_stb_i, cti: wb_m0_cti_i, bte: wb_m0_bte_i};
    assign req_m1 = '{adr: wb_m1_adr_i, dat: wb_m1_dat_i, sel: wb_m1_sel_i, we: wb_m1_we_i,
                      cyc: wb_m1_cyc_i, stb: wb_m1_stb_i, cti: wb_m1_cti_i, bte: wb_m1_bte_i};

    // Grant comes only from the registered owner, so no master input reaches arbitration.
    assign req_own = (owner == M1) ? req_m1 : req_m0;
    assign req_io  = (state == S_BUSY) ? req_own : '0;

    assign wb_io_adr_o = req_io.adr;
    assign wb_io_dat_o = req_io.dat;
    assign wb_io_sel_o = req_io.sel;
    assign wb_io_we_o  = req_io.we;
    assign wb_io_cyc_o = req_io.cyc;
    assign wb_io_stb_o = req_io.stb;
    assign wb_io_cti_o = req_io.cti;
    assign wb_io_bte_o = req_io.bte;

    always_comb begin
        rsp_own = '0;
        if (state == S_BUSY) begin
            rsp_own = '{dat: wb_io_dat_i, ack: wb_io_ack_i, err: wb_io_err_i, rty: wb_io_rty_i};
        end else if (state == S_ABORT) begin
            rsp_own.err = 1'b1;
        end
    end

    assign {wb_m0_dat_o, wb_m0_ack_o, wb_m0_err_o, wb_m0_rty_o} = (owner == M0) ? rsp_own : '0;
    assign {wb_m1_dat_o, wb_m1_ack_o, wb_m1_err_o, wb_m1_rty_o} = (owner == M1) ? rsp_own : '0;

    // A termination in the expiry cycle clears the counter and suppresses the abort.
    assign term    = wb_io_ack_i | wb_io_err_i | wb_io_rty_i;
    assign cnt_en  = (state == S_BUSY) && req_own.stb;
    assign cnt_clr = !cnt_en || term;

    wb_tmo_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tmo_cnt (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .expire_c (expire_c)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= S_IDLE;
            owner     <= M0;
            last      <= M1;
            tmo_o     <= 1'b0;
            tmo_adr_o <= '0;
            tmo_mst_o <= 1'b0;
        end else begin
            tmo_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wb_m0_cyc_i && wb_m1_cyc_i) begin
                        owner <= ~last;
                        state <= S_BUSY;
                    end else if (wb_m0_cyc_i) begin
                        owner <= M0;
                        state <= S_BUSY;
                    end else if (wb_m1_cyc_i) begin
                        owner <= M1;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!req_own.cyc) begin
                        last  <= owner;
                        state <= S_IDLE;
                    end else if (expire_c) begin
                        tmo_o     <= 1'b1;
                        tmo_adr_o <= req_own.adr;
                        tmo_mst_o <= owner;
                        state     <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    last  <= owner;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Directed and random checks of wb_io_arbiter against a transaction-rule reference model.
module tb_wb_io_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic [2:0]  m_cti [2];
    logic [1:0]  m_bte [2];
    logic [31:0] d_dat [2];
    logic        d_ack [2];
    logic        d_err [2];
    logic        d_rty [2];
    logic [31:0] io_adr, io_dat;
    logic [3:0]  io_sel;
    logic        io_we, io_cyc, io_stb;
    logic [2:0]  io_cti;
    logic [1:0]  io_bte;
    logic [31:0] s_dat;
    logic        s_ack, s_err, s_rty;
    logic        tmo, tmo_mst;
    logic [31:0] tmo_adr;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the port, whether this is the abort cycle, stall run length.
    int          md_own;
    bit          md_abort;
    bit          md_last;
    int unsigned md_run;
    logic [31:0] md_tadr;
    bit          md_tmst;

    wb_io_arbiter #(.TIMEOUT(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_m0_adr_i (m_adr[0]), .wb_m0_dat_i (m_dat[0]), .wb_m0_sel_i (m_sel[0]),
        .wb_m0_we_i  (m_we[0]),  .wb_m0_cyc_i (m_cyc[0]), .wb_m0_stb_i (m_stb[0]),
        .wb_m0_cti_i (m_cti[0]), .wb_m0_bte_i (m_bte[0]),
        .wb_m0_dat_o (d_dat[0]), .wb_m0_ack_o (d_ack[0]), .wb_m0_err_o (d_err[0]),
        .wb_m0_rty_o (d_rty[0]),
        .wb_m1_adr_i (m_adr[1]), .wb_m1_dat_i (m_dat[1]), .wb_m1_sel_i (m_sel[1]),
        .wb_m1_we_i  (m_we[1]),  .wb_m1_cyc_i (m_cyc[1]), .wb_m1_stb_i (m_stb[1]),
        .wb_m1_cti_i (m_cti[1]), .wb_m1_bte_i (m_bte[1]),
        .wb_m1_dat_o (d_dat[1]), .wb_m1_ack_o (d_ack[1]), .wb_m1_err_o (d_err[1]),
        .wb_m1_rty_o (d_rty[1]),
        .wb_io_adr_o (io_adr), .wb_io_dat_o (io_dat), .wb_io_sel_o (io_sel),
        .wb_io_we_o  (io_we),  .wb_io_cyc_o (io_cyc), .wb_io_stb_o (io_stb),
        .wb_io_cti_o (io_cti), .wb_io_bte_o (io_bte),
        .wb_io_dat_i (s_dat),  .wb_io_ack_i (s_ack),  .wb_io_err_i (s_err),
        .wb_io_rty_i (s_rty),
        .tmo_o       (tmo),
        .tmo_adr_o   (tmo_adr),
        .tmo_mst_o   (tmo_mst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        md_own   = -1;
        md_abort = 1'b0;
        md_last  = 1'b1;
        md_run   = 0;
        md_tadr  = '0;
        md_tmst  = 1'b0;
    endfunction

    function automatic void model_step();
        if (md_own < 0) begin
            md_run = 0;
            if (m_cyc[0] && m_cyc[1]) md_own = md_last ? 0 : 1;
            else if (m_cyc[0])        md_own = 0;
            else if (m_cyc[1])        md_own = 1;
        end else if (md_abort) begin
            md_last  = (md_own == 1);
            md_own   = -1;
            md_abort = 1'b0;
        end else if (!m_cyc[md_own]) begin
            md_last = (md_own == 1);
            md_own  = -1;
        end else if (m_stb[md_own] && !(s_ack || s_err || s_rty)) begin
            md_run++;
            if (md_run == TMO) begin
                md_abort = 1'b1;
                md_tadr  = m_adr[md_own];
                md_tmst  = (md_own == 1);
                md_run   = 0;
            end
        end else begin
            md_run = 0;
        end
    endfunction

    // Compare every DUT output against the model at the falling edge, then advance the model.
    task automatic sample();
        logic [31:0] e_adr, e_dat;
        logic [11:0] e_ctl;
        logic [31:0] e_rdat [2];
        logic [2:0]  e_rsp  [2];
        @(negedge clk);
        if (!rst_n) model_reset();
        e_adr = '0;
        e_dat = '0;
        e_ctl = '0;
        for (int i = 0; i < 2; i++) begin
            e_rdat[i] = '0;
            e_rsp[i]  = '0;
        end
        if (md_own >= 0 && !md_abort) begin
            e_adr = m_adr[md_own];
            e_dat = m_dat[md_own];
            e_ctl = {m_sel[md_own], m_we[md_own], m_cyc[md_own], m_stb[md_own],
                     m_cti[md_own], m_bte[md_own]};
            e_rdat[md_own] = s_dat;
            e_rsp[md_own]  = {s_ack, s_err, s_rty};
        end else if (md_own >= 0) begin
            e_rsp[md_own] = 3'b010;
        end
        check_eq("io_adr", io_adr, e_adr);
        check_eq("io_dat", io_dat, e_dat);
        check_eq("io_ctl", 32'({io_sel, io_we, io_cyc, io_stb, io_cti, io_bte}), 32'(e_ctl));
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("m%0d_dat", i), d_dat[i], e_rdat[i]);
            check_eq($sformatf("m%0d_rsp", i), 32'({d_ack[i], d_err[i], d_rty[i]}), 32'(e_rsp[i]));
        end
        check_eq("tmo_flags", 32'({tmo, tmo_mst}), 32'({md_abort, md_tmst}));
        check_eq("tmo_adr", tmo_adr, md_tadr);
        if (rst_n) model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_we[i] = 1'b0;
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_cti[i] = '0; m_bte[i] = '0;
        end
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic set_req(input int m, input logic [31:0] adr, input logic we, input logic [2:0] cti);
        m_adr[m] = adr;
        m_dat[m] = $urandom;
        m_sel[m] = 4'hF;
        m_we[m]  = we;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_cti[m] = cti;
        m_bte[m] = 2'b00;
    endtask

    task automatic drop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int          o;
        int          silent;
        int          r;
        int          beats  [2];
        bit          active [2];
        logic [2:0]  obs    [2];
        logic [31:0] tie_adr [2];

        model_reset();
        rst_n = 1'b0;
        clear_inputs();
        advance();
        advance();
        rst_n = 1'b1;
        cycle();

        // Single master read with two wait states.
        set_req(0, 32'h1040, 1'b0, 3'b000);
        sample(); check_eq("lat_idle", 32'(io_cyc), 32'd0); advance();
        sample(); check_eq("lat_busy", 32'(io_cyc), 32'd1); advance();
        cycle();
        s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        sample();
        check_eq("rd_ack", 32'(d_ack[0]), 32'd1);
        check_eq("rd_dat", d_dat[0], 32'hDEADBEEF);
        check_eq("rd_m1_dat", d_dat[1], 32'd0);
        check_eq("rd_m1_rsp", 32'({d_ack[1], d_err[1], d_rty[1]}), 32'd0);
        advance();
        s_ack = 1'b0; drop(0);
        cycle(); cycle();

        // Tie out of reset: grants alternate m0, m1, m0, m1 with one idle cycle between.
        do_reset();
        tie_adr[0] = 32'h0000_0100;
        tie_adr[1] = 32'h0000_0200;
        set_req(0, tie_adr[0], 1'b0, 3'b000);
        set_req(1, tie_adr[1], 1'b1, 3'b000);
        sample(); check_eq("tie_first_idle", 32'(io_cyc), 32'd0); advance();
        for (int k = 0; k < 4; k++) begin
            o = k % 2;
            s_ack = 1'b1; s_dat = $urandom;
            sample();
            check_eq("tie_owner", io_adr, tie_adr[o]);
            check_eq("tie_ack", 32'(d_ack[o]), 32'd1);
            check_eq("tie_other_ack", 32'(d_ack[1-o]), 32'd0);
            advance();
            s_ack = 1'b0; drop(o);
            sample(); check_eq("tie_drop", 32'(io_cyc), 32'd0); advance();
            m_cyc[o] = 1'b1; m_stb[o] = 1'b1;
            sample(); check_eq("tie_gap", 32'(io_cyc), 32'd0); advance();
        end
        clear_inputs();
        cycle(); cycle(); cycle();

        // Four-beat incrementing burst by m1 while m0 waits.
        set_req(1, 32'h2000, 1'b0, 3'b010);
        cycle();
        set_req(0, 32'h3000, 1'b0, 3'b000);
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1; s_dat = $urandom;
            m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
            sample();
            check_eq("burst_adr", io_adr, 32'h2000 + 32'(b * 4));
            check_eq("burst_cti", 32'(io_cti), (b == 3) ? 32'd7 : 32'd2);
            check_eq("burst_cyc", 32'(io_cyc), 32'd1);
            check_eq("burst_m0_wait", 32'(d_ack[0]), 32'd0);
            advance();
            m_adr[1] = m_adr[1] + 32'd4;
        end
        s_ack = 1'b0; drop(1);
        cycle(); cycle();
        sample(); check_eq("burst_m0_next", io_adr, 32'h3000); advance();
        drop(0);
        cycle(); cycle();

        // Watchdog abort: silent slave.
        set_req(0, 32'h1500, 1'b0, 3'b000);
        cycle();
        for (int c = 1; c <= int'(TMO); c++) begin
            sample();
            check_eq("tmo_wait_cyc", 32'(io_cyc), 32'd1);
            check_eq("tmo_wait_pulse", 32'(tmo), 32'd0);
            advance();
        end
        sample();
        check_eq("abort_cyc", 32'(io_cyc), 32'd0);
        check_eq("abort_err", 32'(d_err[0]), 32'd1);
        check_eq("abort_pulse", 32'(tmo), 32'd1);
        check_eq("abort_adr", tmo_adr, 32'h1500);
        check_eq("abort_mst", 32'(tmo_mst), 32'd0);
        advance();
        drop(0);
        sample();
        check_eq("abort_err_once", 32'(d_err[0]), 32'd0);
        check_eq("abort_pulse_once", 32'(tmo), 32'd0);
        advance();
        cycle();

        // Ack in the last waiting cycle beats the watchdog and restarts the count.
        set_req(0, 32'h1600, 1'b0, 3'b000);
        cycle();
        for (int c = 1; c < int'(TMO); c++) cycle();
        s_ack = 1'b1; s_dat = $urandom;
        sample();
        check_eq("race_ack", 32'(d_ack[0]), 32'd1);
        check_eq("race_no_tmo", 32'(tmo), 32'd0);
        advance();
        s_ack = 1'b0;
        for (int c = 1; c < int'(TMO); c++) begin
            sample();
            check_eq("race_cleared", 32'(io_cyc), 32'd1);
            check_eq("race_cleared_tmo", 32'(tmo), 32'd0);
            advance();
        end
        check_eq("race_tmo_adr", tmo_adr, 32'h1500);
        drop(0);
        cycle(); cycle();

        // Asynchronous reset in the middle of an m1 burst.
        set_req(1, 32'h4000, 1'b0, 3'b010);
        cycle();
        s_ack = 1'b1;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_io_cyc", 32'(io_cyc), 32'd0);
        check_eq("rst_io_stb", 32'(io_stb), 32'd0);
        check_eq("rst_m1_ack", 32'(d_ack[1]), 32'd0);
        check_eq("rst_tmo_adr", tmo_adr, 32'd0);
        check_eq("rst_tmo", 32'({tmo, tmo_mst}), 32'd0);
        cycle();
        s_ack = 1'b0;
        set_req(0, 32'h5000, 1'b0, 3'b000);
        cycle();
        rst_n = 1'b1;
        cycle();
        sample(); check_eq("rst_tie_m0", io_adr, 32'h5000); advance();
        clear_inputs();
        cycle(); cycle();

        // Random traffic from both masters against a slave with random terminations and stalls.
        silent = 0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0;
            beats[i]  = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            if (silent > 0) begin
                silent--;
                s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            end else begin
                r = int'($urandom_range(0, 99));
                s_ack = (r < 35);
                s_err = (r >= 35 && r < 38);
                s_rty = (r >= 38 && r < 41);
                if (r == 99) silent = 12;
            end
            s_dat = $urandom;
            sample();
            for (int m = 0; m < 2; m++) obs[m] = {d_ack[m], d_err[m], d_rty[m]};
            advance();
            for (int m = 0; m < 2; m++) begin
                if (!active[m]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        active[m] = 1'b1;
                        beats[m]  = int'($urandom_range(1, 4));
                        set_req(m, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                                (beats[m] > 1) ? 3'b010 : 3'b000);
                    end
                end else if (obs[m][1] || obs[m][0]) begin
                    drop(m);
                    active[m] = 1'b0;
                end else if (obs[m][2]) begin
                    beats[m]--;
                    if (beats[m] == 0) begin
                        drop(m);
                        active[m] = 1'b0;
                    end else begin
                        m_adr[m] = m_adr[m] + 32'd4;
                        m_dat[m] = $urandom;
                        m_stb[m] = 1'b1;
                        if (beats[m] == 1) m_cti[m] = 3'b111;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    m_stb[m] = ~m_stb[m];
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_io_arbiter.md
# wb_io_arbiter

Two-master Wishbone arbiter that shares the single wb_io master port of the IO interconnect between the CPU bus bridge (master 0) and a secondary master such as DMA or debug (master 1). It grants round-robin on cycle boundaries and holds the grant for the whole `cyc` period, so bursts are atomic. A per-transfer watchdog aborts any access that gets no slave termination, returns `err` to the owner and records the failing address. It sits directly upstream of the IO interconnect's wb_io_* inputs.

## Interface
- TIMEOUT, 1023: consecutive unterminated strobe cycles before abort; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT+1): watchdog counter width.
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- wb_m{0,1}_adr_i / dat_i  in  32 each  master address / write data.
- wb_m{0,1}_sel_i  in  4  byte selects.
- wb_m{0,1}_we_i, cyc_i, stb_i  in  1 each  write enable / cycle / strobe.
- wb_m{0,1}_cti_i  in  3  cycle type; wb_m{0,1}_bte_i  in  2  burst type.
- wb_m{0,1}_dat_o  out  32  read data; zero when the master is not the owner.
- wb_m{0,1}_ack_o, err_o, rty_o  out  1 each  terminations; only the owner sees nonzero values.
- wb_io_adr_o, dat_o  out  32 each  to interconnect; wb_io_sel_o  out  4.
- wb_io_we_o, cyc_o, stb_o  out  1 each; wb_io_cti_o  out  3; wb_io_bte_o  out  2.
- wb_io_dat_i  in  32; wb_io_ack_i, err_i, rty_i  in  1 each  from interconnect.
- tmo_o  out  1  one-cycle pulse on watchdog abort.
- tmo_adr_o  out  32  address of the last aborted access.
- tmo_mst_o  out  1  master index of the last aborted access.

## Operation
- States:
  - IDLE: no grant; all wb_io_* outputs 0.
  - BUSY: owner's request signals pass combinationally to wb_io_*, and wb_io responses pass combinationally to the owner.
  - ABORT: lasts one cycle.
- Registers: `owner` (1 bit) and `last` (last owner, reset 1, so m0 wins the first tie).
- IDLE transitions:
  - No `cyc`: stay in IDLE.
  - One master has `cyc`: owner = that master, go to BUSY.
  - Both have `cyc`: owner = !last, go to BUSY.
- BUSY transitions:
  - Owner drops `cyc`: go to IDLE, last = owner. wb_io_cyc_o falls in the same cycle.
  - Watchdog expires: go to ABORT.
- ABORT cycle:
  - wb_io_cyc_o and wb_io_stb_o forced 0.
  - Owner receives err_o = 1.
  - tmo_o = 1; tmo_adr_o and tmo_mst_o are captured from the owner.
  - Next state IDLE, last = owner.
- Watchdog counter (CNT_W bits):
  - Cleared when outside BUSY, when owner `stb` is low, or on any ack/err/rty.
  - In BUSY with owner `stb` high and no termination: if count == TIMEOUT-1, go to ABORT next cycle; otherwise count + 1.
  - The counter never wraps.
- Simultaneous events:
  - A termination in the cycle the counter would expire wins: no abort, normal completion.
  - A non-owner request during BUSY or ABORT waits; it is never dropped.
- Burst handling: cti/bte pass through unmodified; no re-arbitration inside a `cyc`.
- Reset values: state IDLE, owner 0, last 1, count 0, every output 0 (including tmo_adr_o and tmo_mst_o).
- Asynchronous reset mid-transfer clears everything immediately; the downstream `cyc` drops without termination.

## Timing
- Arbitration latency: one cycle from `cyc` rising in IDLE to wb_io_cyc_o high.
- Back-to-back owners are separated by exactly one IDLE cycle.
- Response path from wb_io_ack/err/rty/dat_i to owner: zero cycles, combinational.
- Abort occurs TIMEOUT cycles after the first unterminated strobe cycle. Owner err_o is high for exactly one cycle.
- No combinational path from master inputs to the arbiter's grant decision within a cycle; grant comes from registered state only.

## Structure
- Shared package/include wb_arb_pkg:
  - State encoding localparams: S_IDLE = 2'd0, S_BUSY = 2'd1, S_ABORT = 2'd2.
  - Master index constants.
- Sub-module wb_tmo_cnt: watchdog counter with clear/enable/expire, parameterised by TIMEOUT and CNT_W. It ties expire to 0 when TIMEOUT == 0.
- The top level holds the FSM, owner/last registers, muxes and status registers.

## Test plan
- Single master: m0 reads 0x1040, slave acks at wait state 2. m0 ack_o is asserted in the same cycle as the slave ack, dat_o = 0xDEADBEEF, m1 sees all zeros.
- Tie: m0 and m1 both assert `cyc` out of reset. m0 is granted first; after m0 drops `cyc`, one IDLE cycle, then m1 is granted. Repeat: grants alternate m0, m1, m0, m1.
- Burst atomicity: m1 runs a 4-beat incrementing burst (cti = 3'b010 then 3'b111) while m0 requests. m0 waits until m1 drops `cyc`, and all 4 beats reach wb_io without interruption.
- Timeout, TIMEOUT = 8: m0 strobes 0x1500 and the slave never responds. ABORT occurs in the 9th BUSY cycle, m0 err_o pulses once, tmo_adr_o = 0x1500, tmo_mst_o = 0, and wb_io_cyc_o is 0 in ABORT.
- Race, TIMEOUT = 8: the slave acks in the 8th waiting cycle. Normal ack, no tmo_o, counter cleared.
- Reset mid-burst: wb_rst_n_i is pulled low asynchronously. All outputs go to 0 within the same cycle, and after release m0 wins the first tie.
